// File: rtl/mig_port_responder.sv
// -----------------------------------------------------------------------------
// mig_port_responder
//
// Stand-in for the user side of one MIG DDR2 port. An initiator (framebuffer,
// Mandelbrot engine) wires its p0-style command / write / read FIFO signals
// here instead of to ddr_interface; accesses are served from an on-chip word
// memory of 2**ADDR_BITS 64-bit words.
//
// Optional build macro: MIG_RESP_PRELOAD_EN
//   defined   - memory is swept during calibration with a recognisable
//               pattern, and calibration lasts max(CALIB_CYCLES, 2**ADDR_BITS)
//   undefined - no sweep, calibration lasts CALIB_CYCLES
//
// Ports
//   clk, reset_n        port clock, synchronous active-low reset
//   calib_done          memory ready; commands and writes accepted after this
//   cmd_*               command strobe, instruction, burst length-1, byte addr
//   cmd_full            command FIFO full
//   wr_*                write FIFO push side, flags, occupancy, sticky underrun
//   rd_*                read FIFO pop side (first-word-fall-through), flags,
//                       occupancy, sticky error
// -----------------------------------------------------------------------------
module mig_port_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int CMD_DEPTH    = 4,
    parameter int CALIB_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        calib_done,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [29:0] cmd_byte_addr,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_mask,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    input  logic        rd_en,
    output logic [63:0] rd_data,
    output logic        rd_empty,
    output logic        rd_full,
    output logic [6:0]  rd_count,
    output logic        rd_error
);
    localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef MIG_RESP_PRELOAD_EN
    localparam int CALIB_LEN = (CALIB_CYCLES > DEPTH) ? CALIB_CYCLES : DEPTH;
`else
    localparam int CALIB_LEN = CALIB_CYCLES;
`endif
    localparam int CALIB_W = $clog2(CALIB_LEN) + 1;
    localparam int CMD_AW  = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WRITE, S_READ} state_t;

    typedef struct packed {
        logic [2:0]           instr;
        logic [5:0]           bl;
        logic [ADDR_BITS-1:0] addr;
    } cmd_t;

    state_t state, state_nx;

    // Command FIFO
    cmd_t              cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0] cmd_wptr, cmd_rptr;
    logic [CMD_AW:0]   cmd_cnt;
    cmd_t              cmd_head;
    logic              cmd_push, cmd_pop;

    // Write FIFO (data + mask) and read FIFO, both 64 deep
    logic [63:0] wf_data [64];
    logic [7:0]  wf_mask [64];
    logic [5:0]  wf_wptr, wf_rptr;
    logic        wf_push, wf_pop;
    logic [63:0] rf_data [64];
    logic [5:0]  rf_wptr, rf_rptr;
    logic        rf_push, rf_pop, rf_room;

    // Word memory and burst datapath
    logic [63:0]          mem [DEPTH];
    logic [63:0]          mem_q, mem_wdata;
    logic [7:0]           mem_wbe;
    logic [ADDR_BITS-1:0] mem_waddr, cur_addr;
    logic                 mem_we, mem_re, rd_pipe_v;
    logic [6:0]           words_left;
    logic                 load_cmd, underrun_stall;
    logic [CALIB_W-1:0]   calib_cnt;
    logic                 calib_last;

    // Address bits below the word and above the memory, and the auto-precharge
    // flag, have no meaning for an on-chip memory.
    logic unused_bits;
    assign unused_bits = ^{cmd_byte_addr[2:0], cmd_byte_addr[29:ADDR_BITS+3], cmd_head.instr[1]};

    assign calib_done = (state != S_CALIB);
    assign calib_last = (calib_cnt == CALIB_W'(CALIB_LEN - 1));

    assign cmd_full = (cmd_cnt == (CMD_AW + 1)'(CMD_DEPTH));
    assign cmd_head = cmd_mem[cmd_rptr];
    assign cmd_push = cmd_en && calib_done && !cmd_full;

    assign wr_full  = (wr_count == 7'd64);
    assign wr_empty = (wr_count == 7'd0);
    assign wf_push  = wr_en && calib_done && !wr_full;

    assign rd_full  = (rd_count == 7'd64);
    assign rd_empty = (rd_count == 7'd0);
    assign rf_push  = rd_pipe_v;
    assign rf_pop   = rd_en && !rd_empty;
    assign rd_data  = rd_empty ? 64'd0 : rf_data[rf_rptr];
    // A read may issue only if the word it returns is guaranteed a slot.
    assign rf_room  = (({6'd0, rd_pipe_v} + rd_count) < 7'd64);

`ifdef MIG_RESP_PRELOAD_EN
    logic [31:0] sweep_idx;
    assign sweep_idx = 32'(calib_cnt[ADDR_BITS-1:0]);
`endif

    // NOTE: state-holding blocks use non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_CALIB;
            calib_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_CALIB) calib_cnt <= calib_cnt + CALIB_W'(1);
        end
    end

    always_comb begin
        // NOTE: every signal driven here is given a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nx       = state;
        cmd_pop        = 1'b0;
        wf_pop         = 1'b0;
        mem_we         = 1'b0;
        mem_wbe        = 8'h00;
        mem_waddr      = cur_addr;
        mem_wdata      = wf_data[wf_rptr];
        mem_re         = 1'b0;
        load_cmd       = 1'b0;
        underrun_stall = 1'b0;
        unique case (state)
            S_CALIB: begin
`ifdef MIG_RESP_PRELOAD_EN
                mem_we    = (calib_cnt < CALIB_W'(DEPTH));
                mem_wbe   = 8'hFF;
                mem_waddr = calib_cnt[ADDR_BITS-1:0];
                mem_wdata = {32'hA5A5_0000 | {16'h0000, sweep_idx[15:0]}, sweep_idx};
`endif
                if (calib_last) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_cnt != '0) begin
                    cmd_pop = 1'b1;
                    if (!cmd_head.instr[2]) begin
                        load_cmd = 1'b1;
                        state_nx = cmd_head.instr[0] ? S_READ : S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!wr_empty) begin
                    wf_pop  = 1'b1;
                    mem_we  = 1'b1;
                    mem_wbe = ~wf_mask[wf_rptr];
                    if (words_left == 7'd1) state_nx = S_IDLE;
                end else begin
                    underrun_stall = 1'b1;
                end
            end
            S_READ: begin
                mem_re = (words_left != 7'd0) && rf_room;
                // The last word is being pushed this cycle.
                if (words_left == 7'd0 && rd_pipe_v) state_nx = S_IDLE;
            end
        endcase
    end

    // Burst address / remaining count; in READ, words_left counts issues.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_addr   <= '0;
            words_left <= 7'd0;
            rd_pipe_v  <= 1'b0;
        end else begin
            rd_pipe_v <= mem_re;
            if (load_cmd) begin
                cur_addr   <= cmd_head.addr;
                words_left <= 7'(cmd_head.bl) + 7'd1;
            end else if (wf_pop || mem_re) begin
                cur_addr   <= cur_addr + ADDR_BITS'(1);
                words_left <= words_left - 7'd1;
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy is governed by the reset
    // pointers and counts, and memory contents must survive reset anyway.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (mem_we && mem_wbe[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        if (mem_re) mem_q <= mem[cur_addr];
        if (cmd_push) cmd_mem[cmd_wptr] <= {cmd_instr, cmd_bl, cmd_byte_addr[ADDR_BITS+2:3]};
        if (wf_push) begin
            wf_data[wf_wptr] <= wr_data;
            wf_mask[wf_wptr] <= wr_mask;
        end
        if (rf_push) rf_data[rf_wptr] <= mem_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            cmd_cnt  <= '0;
            wf_wptr  <= 6'd0;
            wf_rptr  <= 6'd0;
            wr_count <= 7'd0;
            rf_wptr  <= 6'd0;
            rf_rptr  <= 6'd0;
            rd_count <= 7'd0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + CMD_AW'(1);
            if (cmd_pop)  cmd_rptr <= cmd_rptr + CMD_AW'(1);
            if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + (CMD_AW + 1)'(1);
            else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - (CMD_AW + 1)'(1);

            if (wf_push) wf_wptr <= wf_wptr + 6'd1;
            if (wf_pop)  wf_rptr <= wf_rptr + 6'd1;
            if (wf_push && !wf_pop)      wr_count <= wr_count + 7'd1;
            else if (!wf_push && wf_pop) wr_count <= wr_count - 7'd1;

            if (rf_push) rf_wptr <= rf_wptr + 6'd1;
            if (rf_pop)  rf_rptr <= rf_rptr + 6'd1;
            if (rf_push && !rf_pop)      rd_count <= rd_count + 7'd1;
            else if (!rf_push && rf_pop) rd_count <= rd_count - 7'd1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_underrun <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            if (underrun_stall || (wr_en && calib_done && wr_full)) wr_underrun <= 1'b1;
            if ((cmd_en && calib_done && cmd_full) || (rd_en && rd_empty)) rd_error <= 1'b1;
        end
    end

endmodule

// File: doc/mig_port_responder.md
Name: mig_port_responder

Overview:
- Synthesizable responder for the user side of one MIG DDR2 port: command FIFO, write-data FIFO and read-data FIFO, backed by an on-chip block-RAM word memory instead of the DDR2 device.
- Lets framebuffer and Mandelbrot-engine logic that drive a port be simulated and brought up on hardware without the memory controller.
- Sits where ddr_interface would be: the initiator connects its p0-style signals directly to this block.

Parameters:
- ADDR_BITS, 10, word-address width; memory depth = 2**ADDR_BITS 64-bit words.
- CMD_DEPTH, 4, command FIFO entries (power of two).
- CALIB_CYCLES, 256, cycles from reset release to calib_done rising.

Ports:
- clk  in  1  port clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- calib_done  out  1  memory ready.
- cmd_en  in  1  one-cycle command strobe.
- cmd_instr  in  3  000 write, 001 read, 010 write+AP, 011 read+AP, 1xx refresh.
- cmd_bl  in  6  burst length minus one (1..64 words).
- cmd_byte_addr  in  30  byte address; bits [2:0] ignored.
- cmd_full  out  1  command FIFO full.
- wr_en  in  1  push wr_data/wr_mask.
- wr_data  in  64  write word.
- wr_mask  in  8  per-byte mask; 1 = byte not written.
- wr_full  out  1  write FIFO holds 64.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy, 0..64.
- wr_underrun  out  1  sticky error.
- rd_en  in  1  pop read FIFO.
- rd_data  out  64  head of read FIFO (first-word-fall-through).
- rd_empty  out  1  read FIFO empty.
- rd_full  out  1  read FIFO holds 64.
- rd_count  out  7  read FIFO occupancy, 0..64.
- rd_error  out  1  sticky error.

Behaviour:
- Reset (reset_n low at posedge):
  - calib_done=0; all FIFOs empty; counts=0; wr_empty=1; rd_empty=1.
  - cmd_full=0; wr_full=0; rd_full=0; wr_underrun=0; rd_error=0; rd_data=0.
  - FSM returns to CALIB, abandoning any burst in progress; memory contents are kept.
- CALIB: counts CALIB_CYCLES cycles, then goes to IDLE and calib_done=1.
  - Commands and wr_en during CALIB are ignored.
  - wr_en is accepted once calib_done=1.
- Command FIFO:
  - Push when cmd_en=1 and not cmd_full.
  - cmd_en while full: command dropped, rd_error set.
- IDLE: when the command FIFO is non-empty, pop one entry.
  - instr 1xx: discarded, stay IDLE, one cycle.
  - x00 or x10 (write): go to WRITE.
  - x01 or x11 (read): go to READ.
  - Word address = cmd_byte_addr[ADDR_BITS+2:3]; burst words n = cmd_bl+1.
- WRITE: each cycle the write FIFO is non-empty, pop one word and write the unmasked bytes to mem[addr].
  - Then addr=addr+1 mod 2**ADDR_BITS (wraps silently); decrement remaining.
  - Write FIFO empty with words remaining: stall, wr_underrun set (sticky).
  - After the n-th word: back to IDLE.
- READ: issue one memory read per cycle while reads-in-flight + rd_count < 64.
  - Memory latency 1 cycle; the word is pushed into the read FIFO the next cycle.
  - Same address wrap as WRITE.
  - After the n-th push: back to IDLE. Never overflows; the FSM stalls instead.
- FIFOs: 64 deep.
  - Simultaneous push and pop: occupancy unchanged.
  - wr_en while wr_full: word dropped, wr_underrun set.
  - rd_en while rd_empty: ignored, rd_error set.
  - rd_data is valid whenever rd_empty=0 and updates the cycle after a pop.
- Ordering: commands complete strictly in order. Read-after-write to the same address returns the new data.
- The sticky errors wr_underrun and rd_error clear only on reset.

Optional Feature:
- Macro MIG_RESP_PRELOAD_EN.
- Defined: during CALIB, memory is swept, writing mem[i] = {32'hA5A5_0000 | i[15:0], 32'(i)} for every word i.
  - calib_done rises after max(CALIB_CYCLES, 2**ADDR_BITS) cycles.
- Undefined: no sweep; memory is undefined after configuration and unchanged by reset; calib_done rises after CALIB_CYCLES cycles.

Test Plan:
- Calibration: release reset, hold cmd_en=1 during CALIB -> calib_done rises exactly CALIB_CYCLES cycles after release; command FIFO stays empty.
- Write then read back: push words 1..6, write cmd bl=5 addr=16; then read cmd bl=5 addr=16 -> rd_count reaches 6; popping gives 1,2,3,4,5,6; then rd_empty=1.
- Byte mask: write 64'hFFFF_FFFF_FFFF_FFFF to addr 0, then 64'h0 with mask 8'h0F -> read back 64'h0000_0000_FFFF_FFFF.
- Read stall and address wrap: read bl=63 at the last word address with rd_en=0 -> rd_full=1 and rd_count=64, no data lost; subsequent words come from addresses 0..62.
- Errors: write cmd bl=3 with only 2 words queued -> wr_underrun=1, FSM stalls; pushing 2 more words completes the burst. rd_en with rd_empty=1 -> rd_error=1.
- Reset and refresh: reset_n low mid-READ -> FIFOs empty, calib_done=0, error flags 0. A refresh cmd (instr 100) is consumed with no memory or FIFO change.
